h_packer: RTL and testbench
===========================

# h_packer

Streaming CSR packer for the scheduler stage: it is the writer on the scheduler-to-loader interface. It accepts a dense node-feature matrix H one element per cycle in row-major order and drops zeros. It builds the compressed `col_idx` / `value` / `node_info` arrays that `H_loader` unpacks, then presents them under a valid/ready handshake. Its `sched_valid_o` / `sched_ready_i` pair connects directly to the loader's `sched_valid_i` / `sched_ready_o`.

## Interface
Parameters:
- `DATA_WIDTH`, 8, element width.
- `NUM_OF_COLS`, 5, columns per row. Must not be a power of two, so that `ROW_LEN_WIDTH` can hold `NUM_OF_COLS`.
- `NUM_OF_ROWS`, 5, rows per frame.
- `COL_INDEX_SIZE`, 8, depth of `col_idx_o`. Power of two.
- `VALUE_SIZE`, 8, depth of `value_o`. Must equal `COL_INDEX_SIZE`.
- `NODE_INFO_SIZE`, 5, depth of `node_info_o`. Must be ≥ `NUM_OF_ROWS`.
- Derived widths: `COL_IDX_WIDTH`=$clog2(NUM_OF_COLS), `INDEX_WIDTH`=$clog2(COL_INDEX_SIZE), `ROW_LEN_WIDTH`=$clog2(NUM_OF_COLS), `NODE_INFO_WIDTH`=INDEX_WIDTH+ROW_LEN_WIDTH+1.

Ports:
- `clk`  in  1  the single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `elem_valid_i`  in  1  dense element present.
- `elem_data_i`  in  DATA_WIDTH  dense element value.
- `elem_ready_o`  out  1  packer accepts an element this cycle.
- `sched_valid_o`  out  1  packed frame complete and stable.
- `sched_ready_i`  in  1  consumer takes the frame.
- `col_idx_o[0:COL_INDEX_SIZE-1]`  out  COL_IDX_WIDTH each  column of each stored nonzero.
- `value_o[0:VALUE_SIZE-1]`  out  DATA_WIDTH each  stored nonzero values.
- `node_info_o[0:NODE_INFO_SIZE-1]`  out  NODE_INFO_WIDTH each  per-row info, packed as {start idx, row_len, flag}.
- `overflow_o`  out  1  sticky overflow flag. Present only with `H_PACKER_OVERFLOW_EN`.

## Operation
- States: FILL and DONE. Reset enters FILL.
- Counters:
  - `row_cnt` covers 0..NUM_OF_ROWS-1.
  - `col_cnt` covers 0..NUM_OF_COLS-1 and wraps to 0 at the end of each row.
  - `nnz_cnt` covers 0..COL_INDEX_SIZE.
  - `row_start` latches `nnz_cnt` at the first column of each row.
- FILL: `elem_ready_o`=1. On each accepted element (`elem_valid_i`&&`elem_ready_o`):
  - If `elem_data_i`≠0 and `nnz_cnt`<COL_INDEX_SIZE, write `col_idx_o[nnz_cnt]`=`col_cnt` and `value_o[nnz_cnt]`=`elem_data_i`, then increment `nnz_cnt`.
  - If `elem_data_i`≠0 and `nnz_cnt`=COL_INDEX_SIZE, drop the element (overflow).
  - If `elem_data_i`=0, store nothing; only `col_cnt` advances.
  - At `col_cnt`=NUM_OF_COLS-1, write `node_info_o[row_cnt]` = {row_start clamped to COL_INDEX_SIZE-1, number of elements stored for this row, flag}. Flag is 1 only when `row_cnt`=NUM_OF_ROWS-1.
  - After the last column of the last row, go to DONE.
- DONE: `elem_ready_o`=0 and `sched_valid_o`=1. All array outputs are held stable. On `sched_ready_i`=1:
  - Clear every array entry and all counters.
  - Go to FILL.
- Entries not written (spare `col_idx_o` / `value_o` slots, `node_info_o[NUM_OF_ROWS..]`) read 0.
- A row with no nonzeros produces {start idx = `nnz_cnt`, row_len 0, flag}.

## Timing
- Reset values: `sched_valid_o`=0, `elem_ready_o`=0 while `rst`=1, all arrays 0, `overflow_o`=0.
- In the first cycle after `rst` deasserts, `elem_ready_o`=1.
- Throughput: 1 element per cycle. Gaps in `elem_valid_i` stall the counters and have no other effect.
- Latency: `sched_valid_o` rises in the cycle after the NUM_OF_ROWS×NUM_OF_COLS-th accept.
- Handshake: `sched_valid_o` stays high until `sched_ready_i` is sampled high. In the next cycle `sched_valid_o`=0, the arrays are zero, and `elem_ready_o`=1.
- `sched_ready_i` is ignored in FILL.
- Reset asserted mid-frame or in DONE: the next cycle shows the full reset state and the partial frame is discarded.

## Configuration
- `H_PACKER_OVERFLOW_EN`
  - Defined: the `overflow_o` port exists. It sets on the first dropped nonzero and holds through DONE. It clears on reset or on the DONE handshake.
  - Undefined: the port and its register are absent. Nonzeros beyond COL_INDEX_SIZE are silently dropped with identical array contents.

## Test plan
- Reset: hold `rst` high 2 cycles → `sched_valid_o`=0, all arrays 0, `elem_ready_o`=0. The cycle after release, `elem_ready_o`=1.
- Diagonal 1..5 (defaults) → `col_idx_o`={0,1,2,3,4,0,0,0}, `value_o`={1,2,3,4,5,0,0,0}, `node_info_o[r]`={r,1,0}, and `node_info_o[4]`={4,1,1}. `sched_valid_o` is high the cycle after the 25th accept.
- Row 2 all zero, other rows have 1 nonzero at column 0 → `node_info_o[2]`={2,0,0}, `node_info_o[3]`={2,1,0}.
- Hold `sched_ready_i` low for 10 cycles in DONE → outputs stable and `elem_ready_o`=0. Pulse `sched_ready_i` → next cycle `sched_valid_o`=0, arrays 0, `elem_ready_o`=1.
- 10 nonzeros, with row 0 all 2s and row 1 all 3s, macro on → 8 stored (five 2s, three 3s), `node_info_o[1]`={5,3,0}, `node_info_o[2..4]`={7,0,flag}, `overflow_o`=1. Macro off → same arrays and no port.
- Diagonal stimulus with random 0–3 cycle gaps in `elem_valid_i` → results identical to the gap-free run.

Source files
------------

// File: rtl/h_packer_if.sv
// Scheduler-side bus for h_packer: dense element stream in, packed CSR frame out.
// overflow_o is present only when H_PACKER_OVERFLOW_EN is defined.
interface h_packer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_OF_COLS    = 5,
  parameter int COL_INDEX_SIZE = 8,
  parameter int VALUE_SIZE     = 8,
  parameter int NODE_INFO_SIZE = 5
);
  localparam int COL_IDX_WIDTH   = $clog2(NUM_OF_COLS);
  localparam int INDEX_WIDTH     = $clog2(COL_INDEX_SIZE);
  localparam int ROW_LEN_WIDTH   = $clog2(NUM_OF_COLS);
  localparam int NODE_INFO_WIDTH = INDEX_WIDTH + ROW_LEN_WIDTH + 1;

  logic                       elem_valid_i;
  logic [DATA_WIDTH-1:0]      elem_data_i;
  logic                       elem_ready_o;
  logic                       sched_valid_o;
  logic                       sched_ready_i;
  logic [COL_IDX_WIDTH-1:0]   col_idx_o   [0:COL_INDEX_SIZE-1];
  logic [DATA_WIDTH-1:0]      value_o     [0:VALUE_SIZE-1];
  logic [NODE_INFO_WIDTH-1:0] node_info_o [0:NODE_INFO_SIZE-1];
`ifdef H_PACKER_OVERFLOW_EN
  logic                       overflow_o;
`endif

  // The packer drives the frame towards the loader, so it takes the master side.
  modport master (
    input  elem_valid_i, elem_data_i, sched_ready_i,
`ifdef H_PACKER_OVERFLOW_EN
    output overflow_o,
`endif
    output elem_ready_o, sched_valid_o, col_idx_o, value_o, node_info_o
  );

  modport slave (
    output elem_valid_i, elem_data_i, sched_ready_i,
`ifdef H_PACKER_OVERFLOW_EN
    input  overflow_o,
`endif
    input  elem_ready_o, sched_valid_o, col_idx_o, value_o, node_info_o
  );
endinterface

// File: rtl/h_packer.sv
// Streaming CSR packer: drops zeros from a row-major dense matrix and presents
// col_idx/value/node_info arrays under valid/ready. Optional H_PACKER_OVERFLOW_EN adds overflow_o.
module h_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_OF_COLS    = 5,
  parameter int NUM_OF_ROWS    = 5,
  parameter int COL_INDEX_SIZE = 8,
  parameter int VALUE_SIZE     = 8,
  parameter int NODE_INFO_SIZE = 5
) (
  input logic        clk,
  input logic        rst,
  h_packer_if.master bus
);
  localparam int COL_IDX_WIDTH   = $clog2(NUM_OF_COLS);
  localparam int INDEX_WIDTH     = $clog2(COL_INDEX_SIZE);
  localparam int ROW_LEN_WIDTH   = $clog2(NUM_OF_COLS);
  localparam int NODE_INFO_WIDTH = INDEX_WIDTH + ROW_LEN_WIDTH + 1;
  localparam int NNZ_WIDTH       = INDEX_WIDTH + 1;
  localparam int ROW_CNT_WIDTH   = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

  logic [0:0]                 r_state;
  logic [ROW_CNT_WIDTH-1:0]   r_rowCnt;
  logic [COL_IDX_WIDTH-1:0]   r_colCnt;
  logic [NNZ_WIDTH-1:0]       r_nnzCnt;
  logic [NNZ_WIDTH-1:0]       r_rowStart;
  logic [COL_IDX_WIDTH-1:0]   r_colIdx   [0:COL_INDEX_SIZE-1];
  logic [DATA_WIDTH-1:0]      r_value    [0:VALUE_SIZE-1];
  logic [NODE_INFO_WIDTH-1:0] r_nodeInfo [0:NODE_INFO_SIZE-1];

  logic                       w_ready;
  logic                       w_accept;
  logic                       w_clear;
  logic                       w_full;
  logic                       w_store;
  logic                       w_lastCol;
  logic                       w_lastRow;
  logic [NNZ_WIDTH-1:0]       w_rowStart;
  logic [NNZ_WIDTH-1:0]       w_nnzNext;
  logic [NNZ_WIDTH-1:0]       w_rowStored;
  logic [INDEX_WIDTH-1:0]     w_startIdx;
  logic [NODE_INFO_WIDTH-1:0] w_nodeInfo;

  assign w_ready   = (r_state == FILL) && !rst;
  assign w_accept  = bus.elem_valid_i && w_ready;
  assign w_clear   = (r_state == DONE) && bus.sched_ready_i;
  assign w_full    = (r_nnzCnt == NNZ_WIDTH'(COL_INDEX_SIZE));
  assign w_store   = (bus.elem_data_i != '0) && !w_full;
  assign w_lastCol = (r_colCnt == COL_IDX_WIDTH'(NUM_OF_COLS - 1));
  assign w_lastRow = (r_rowCnt == ROW_CNT_WIDTH'(NUM_OF_ROWS - 1));

  // On a row's first column r_rowStart is only being loaded, so use the live count.
  assign w_rowStart  = (r_colCnt == '0) ? r_nnzCnt : r_rowStart;
  assign w_nnzNext   = r_nnzCnt + NNZ_WIDTH'(w_store);
  assign w_rowStored = w_nnzNext - w_rowStart;
  assign w_startIdx  = (w_rowStart >= NNZ_WIDTH'(COL_INDEX_SIZE)) ?
                       INDEX_WIDTH'(COL_INDEX_SIZE - 1) : w_rowStart[INDEX_WIDTH-1:0];
  assign w_nodeInfo  = {w_startIdx, ROW_LEN_WIDTH'(w_rowStored), w_lastRow};

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_state    <= FILL;
      r_rowCnt   <= '0;
      r_colCnt   <= '0;
      r_nnzCnt   <= '0;
      r_rowStart <= '0;
      for (int i = 0; i < COL_INDEX_SIZE; i++) r_colIdx[i] <= '0;
      for (int i = 0; i < VALUE_SIZE; i++) r_value[i] <= '0;
      for (int i = 0; i < NODE_INFO_SIZE; i++) r_nodeInfo[i] <= '0;
    end else if (w_accept) begin
      if (w_store) begin
        r_colIdx[r_nnzCnt[INDEX_WIDTH-1:0]] <= r_colCnt;
        r_value[r_nnzCnt[INDEX_WIDTH-1:0]]  <= bus.elem_data_i;
      end
      r_nnzCnt <= w_nnzNext;
      if (r_colCnt == '0) r_rowStart <= r_nnzCnt;
      if (w_lastCol) begin
        r_nodeInfo[r_rowCnt] <= w_nodeInfo;
        r_colCnt             <= '0;
        if (w_lastRow) begin
          r_rowCnt <= '0;
          r_state  <= DONE;
        end else begin
          r_rowCnt <= r_rowCnt + 1'b1;
        end
      end else begin
        r_colCnt <= r_colCnt + 1'b1;
      end
    end
  end

`ifdef H_PACKER_OVERFLOW_EN
  logic r_overflow;

  // Sticky until the frame is consumed; w_accept already implies FILL.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_overflow <= 1'b0;
    end else if (w_accept && w_full && (bus.elem_data_i != '0)) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.overflow_o = r_overflow;
`endif

  assign bus.elem_ready_o  = w_ready;
  assign bus.sched_valid_o = (r_state == DONE);
  assign bus.col_idx_o     = r_colIdx;
  assign bus.value_o       = r_value;
  assign bus.node_info_o   = r_nodeInfo;
endmodule

// File: tb/tb_h_packer.sv
// Directed self-checking bench for h_packer (default parameters).
// Overflow-flag checks are compiled in only with H_PACKER_OVERFLOW_EN.
module tb_h_packer;
  logic clk;
  logic rst;

  int errors;
  int checks;

  logic [7:0] mat     [0:24];
  int         expCol  [0:7];
  int         expVal  [0:7];
  int         expNode [0:4];

  h_packer_if #(
    .DATA_WIDTH(8), .NUM_OF_COLS(5), .COL_INDEX_SIZE(8), .VALUE_SIZE(8), .NODE_INFO_SIZE(5)
  ) bus ();

  h_packer #(
    .DATA_WIDTH(8), .NUM_OF_COLS(5), .NUM_OF_ROWS(5),
    .COL_INDEX_SIZE(8), .VALUE_SIZE(8), .NODE_INFO_SIZE(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkArrays(input string tag);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s col_idx[%0d]", tag, i), 32'(bus.col_idx_o[i]), expCol[i]);
      checkOutput($sformatf("%s value[%0d]", tag, i), 32'(bus.value_o[i]), expVal[i]);
    end
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("%s node_info[%0d]", tag, i), 32'(bus.node_info_o[i]), expNode[i]);
  endtask

  task automatic clearExpected();
    for (int i = 0; i < 8; i++) begin
      expCol[i] = 0;
      expVal[i] = 0;
    end
    for (int i = 0; i < 5; i++) expNode[i] = 0;
  endtask

  task automatic loadDiagonal();
    for (int k = 0; k < 25; k++) mat[k] = 8'd0;
    for (int r = 0; r < 5; r++) mat[r * 5 + r] = 8'(r + 1);
    clearExpected();
    for (int r = 0; r < 5; r++) begin
      expCol[r]  = r;
      expVal[r]  = r + 1;
      expNode[r] = (r << 4) | (1 << 1) | ((r == 4) ? 1 : 0);
    end
  endtask

  // Streams mat[] with optional random idle gaps; sched_ready_i may be held high during FILL.
  task automatic applyStimulus(input int maxGap, input bit readyInFill);
    int gap;
    for (int k = 0; k < 25; k++) begin
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bus.elem_valid_i  = 1'b0;
        bus.elem_data_i   = 8'd0;
        bus.sched_ready_i = readyInFill;
      end
      @(negedge clk);
      if (k == 0) checkOutput("ready_in_fill", 32'(bus.elem_ready_o), 1);
      if (k == 24) checkOutput("valid_before_last", 32'(bus.sched_valid_o), 0);
      bus.elem_valid_i  = 1'b1;
      bus.elem_data_i   = mat[k];
      bus.sched_ready_i = (k == 24) ? 1'b0 : readyInFill;
    end
    @(negedge clk);
    bus.elem_valid_i = 1'b0;
    bus.elem_data_i  = 8'd0;
    checkOutput("latency_valid", 32'(bus.sched_valid_o), 1);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bus.sched_ready_i = 1'b1;
    @(negedge clk);
    bus.sched_ready_i = 1'b0;
    clearExpected();
    checkOutput({tag, " hs_valid"}, 32'(bus.sched_valid_o), 0);
    checkOutput({tag, " hs_ready"}, 32'(bus.elem_ready_o), 1);
    checkArrays({tag, " hs"});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.elem_valid_i  = 1'b0;
    bus.elem_data_i   = 8'd0;
    bus.sched_ready_i = 1'b0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    clearExpected();
    checkOutput("rst sched_valid", 32'(bus.sched_valid_o), 0);
    checkOutput("rst elem_ready", 32'(bus.elem_ready_o), 0);
    checkArrays("rst");
`ifdef H_PACKER_OVERFLOW_EN
    checkOutput("rst overflow", 32'(bus.overflow_o), 0);
`endif
    rst = 1'b0;
    #1;
    checkOutput("post_rst elem_ready", 32'(bus.elem_ready_o), 1);

    // Gap-free diagonal, then 10 cycles of back-pressure in DONE.
    $display("[TB] diagonal frame");
    loadDiagonal();
    applyStimulus(0, 1'b0);
    checkArrays("diag");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.elem_valid_i = 1'b1;
      bus.elem_data_i  = 8'd9;
      checkOutput("hold sched_valid", 32'(bus.sched_valid_o), 1);
      checkOutput("hold elem_ready", 32'(bus.elem_ready_o), 0);
    end
    bus.elem_valid_i = 1'b0;
    bus.elem_data_i  = 8'd0;
    checkArrays("diag_hold");
    handshake("diag");

    // Row 2 empty, other rows one nonzero in column 0; sched_ready high during FILL.
    $display("[TB] empty-row frame");
    for (int k = 0; k < 25; k++) mat[k] = 8'd0;
    mat[0] = 8'd7; mat[5] = 8'd7; mat[15] = 8'd7; mat[20] = 8'd7;
    applyStimulus(0, 1'b1);
    clearExpected();
    for (int i = 0; i < 4; i++) expVal[i] = 7;
    expNode[0] = 'h02; expNode[1] = 'h12; expNode[2] = 'h20;
    expNode[3] = 'h22; expNode[4] = 'h33;
    checkArrays("emptyrow");
    handshake("emptyrow");

    // Ten nonzeros overflow the eight slots.
    $display("[TB] overflow frame");
    for (int k = 0; k < 25; k++) mat[k] = 8'd0;
    for (int k = 0; k < 5; k++) begin
      mat[k]     = 8'd2;
      mat[k + 5] = 8'd3;
    end
    applyStimulus(0, 1'b0);
    clearExpected();
    for (int i = 0; i < 5; i++) begin
      expCol[i] = i;
      expVal[i] = 2;
    end
    for (int i = 5; i < 8; i++) begin
      expCol[i] = i - 5;
      expVal[i] = 3;
    end
    expNode[0] = 'h0A; expNode[1] = 'h56; expNode[2] = 'h70;
    expNode[3] = 'h70; expNode[4] = 'h71;
    checkArrays("ovf");
`ifdef H_PACKER_OVERFLOW_EN
    checkOutput("ovf flag", 32'(bus.overflow_o), 1);
    repeat (3) @(negedge clk);
    checkOutput("ovf flag held", 32'(bus.overflow_o), 1);
`endif
    handshake("ovf");
`ifdef H_PACKER_OVERFLOW_EN
    checkOutput("ovf flag cleared", 32'(bus.overflow_o), 0);
`endif

    // Reset part-way through a frame discards it.
    $display("[TB] mid-frame reset");
    loadDiagonal();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus.elem_valid_i = 1'b1;
      bus.elem_data_i  = mat[k];
    end
    @(negedge clk);
    bus.elem_valid_i = 1'b0;
    bus.elem_data_i  = 8'd0;
    rst = 1'b1;
    @(negedge clk);
    clearExpected();
    checkOutput("midrst sched_valid", 32'(bus.sched_valid_o), 0);
    checkOutput("midrst elem_ready", 32'(bus.elem_ready_o), 0);
    checkArrays("midrst");
    rst = 1'b0;

    // Gapped diagonal must match the gap-free result.
    $display("[TB] gapped diagonal frame");
    loadDiagonal();
    applyStimulus(3, 1'b0);
    checkArrays("gapdiag");

    // Reset while in DONE.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clearExpected();
    checkOutput("donerst sched_valid", 32'(bus.sched_valid_o), 0);
    checkOutput("donerst elem_ready", 32'(bus.elem_ready_o), 0);
    checkArrays("donerst");
    rst = 1'b0;
    #1;
    checkOutput("donerst release ready", 32'(bus.elem_ready_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
